// File: rtl/cos_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// cos_pkg : widths, state encoding and 1/((2k-1)(2k)) coefficient ROM for cos_x
// Rev 1.0
// -----------------------------------------------------------------------------
package cos_pkg;

  localparam int IN_X_W    = 16;
  localparam int IN_N_W    = 8;
  localparam int OUT_W     = 16;
  localparam int IW        = 32;
  localparam int FRAC_X    = 8;
  localparam int FRAC_OUT  = 14;
  localparam int FRAC_IW   = 28;
  localparam int MAX_TERMS = 16;
  localparam int K_W       = $clog2(MAX_TERMS);
  localparam int COEF_W    = 16;

  localparam logic [IN_X_W-1:0]    X_MAX   = 16'h01FF;
  localparam logic signed [IW-1:0] ONE_IW  = 32'sh1000_0000;
  localparam logic signed [IW-1:0] TWO_IW  = 32'sh2000_0000;
  localparam logic [OUT_W-1:0]     OUT_POS = 16'h7FFF;
  localparam logic [OUT_W-1:0]     OUT_NEG = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_e;

  // Unsigned Q0.16, round-to-nearest; entry 0 is never addressed.
  localparam logic [COEF_W-1:0] C_ROM [MAX_TERMS] = '{
    16'd0,   16'd32768, 16'd5461, 16'd2185,
    16'd1170, 16'd728,  16'd496,  16'd360,
    16'd273, 16'd214,   16'd172,  16'd142,
    16'd119, 16'd101,   16'd87,   16'd75
  };

  function automatic logic [OUT_W-1:0] sat_q214(input logic signed [IW-1:0] acc);
    logic [OUT_W-1:0] res;
    if (acc >= TWO_IW) begin
      res = OUT_POS;
    end else if (acc < -TWO_IW) begin
      res = OUT_NEG;
    end else begin
      res = acc[FRAC_IW-FRAC_OUT+OUT_W-1:FRAC_IW-FRAC_OUT];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cos_term_step.sv
`default_nettype none
// -----------------------------------------------------------------------------
// cos_term_step : next_term = -(term * x2) * C[k], all values Q4.28
// Rev 1.0
// -----------------------------------------------------------------------------
module cos_term_step
  import cos_pkg::*;
(
  input  logic [IW-1:0]  term_i,
  input  logic [IW-1:0]  x2_i,
  input  logic [K_W-1:0] k_i,
  output logic [IW-1:0]  next_term_o
);

  localparam int P1_W = 2 * IW;
  localparam int P2_W = IW + COEF_W + 1;

  logic signed [P1_W-1:0] w_term_ext;
  logic signed [P1_W-1:0] w_x2_ext;
  logic signed [P1_W-1:0] w_prod_tx;
  logic signed [P2_W-1:0] w_tx_ext;
  logic signed [P2_W-1:0] w_coef_ext;
  logic signed [P2_W-1:0] w_prod_c;
  logic signed [IW-1:0]   w_tx;
  logic signed [IW-1:0]   w_tc;

  logic [P1_W-IW-FRAC_IW-1:0]  w_unused_tx_hi;
  logic [FRAC_IW-1:0]          w_unused_tx_lo;
  logic [P2_W-IW-COEF_W-1:0]   w_unused_c_hi;
  logic [COEF_W-1:0]           w_unused_c_lo;

  assign w_term_ext = {{(P1_W-IW){term_i[IW-1]}}, term_i};
  assign w_x2_ext   = {{(P1_W-IW){x2_i[IW-1]}}, x2_i};
  assign w_prod_tx  = w_term_ext * w_x2_ext;

  // Dropping the low fraction bits of a two's-complement product is an
  // arithmetic shift with truncation toward minus infinity.
  assign {w_unused_tx_hi, w_tx, w_unused_tx_lo} = w_prod_tx;

  assign w_tx_ext   = {{(P2_W-IW){w_tx[IW-1]}}, w_tx};
  assign w_coef_ext = {{(P2_W-COEF_W){1'b0}}, C_ROM[k_i]};
  assign w_prod_c   = w_tx_ext * w_coef_ext;

  assign {w_unused_c_hi, w_tc, w_unused_c_lo} = w_prod_c;

  assign next_term_o = -w_tc;

endmodule
`default_nettype wire

// File: rtl/cos_x.sv
`default_nettype none
// -----------------------------------------------------------------------------
// cos_x : sequential Maclaurin-series cosine, one term per clock, start/done
// Rev 1.0
// -----------------------------------------------------------------------------
module cos_x
  import cos_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IN_X_W-1:0] inX,
  input  logic [IN_N_W-1:0] inY,
  output logic [OUT_W-1:0]  out,
  output logic              done
);

  localparam int X2_SHIFT = FRAC_IW - 2 * FRAC_X;

  state_e            state_q;
  logic [IN_X_W-1:0] x_q;
  logic [K_W-1:0]    n_last_q;
  logic [K_W-1:0]    k_q;
  logic [IW-1:0]     x2_q;
  logic [IW-1:0]     term_q;
  logic [IW-1:0]     acc_q;
  logic [OUT_W-1:0]  out_q;
  logic              done_q;

  logic [IN_X_W-1:0] x_d;
  logic [K_W-1:0]    n_last_d;
  logic [IW-1:0]     w_x_ext;
  logic [IW-1:0]     x2_d;
  logic [IW-1:0]     term_d;
  logic [IW-1:0]     acc_d;

  // The run length is held as N_eff-1 so it compares directly against k.
  always_comb begin
    x_d = (inX > X_MAX) ? X_MAX : inX;
    if (inY == '0) begin
      n_last_d = '0;
    end else if (inY >= IN_N_W'(MAX_TERMS)) begin
      n_last_d = K_W'(MAX_TERMS - 1);
    end else begin
      n_last_d = K_W'(inY - 1'b1);
    end
  end

  assign w_x_ext = {{(IW-IN_X_W){1'b0}}, x_q};
  assign x2_d    = (w_x_ext * w_x_ext) << X2_SHIFT;
  assign acc_d   = acc_q + term_d;

  cos_term_step u_step (
    .term_i      (term_q),
    .x2_i        (x2_q),
    .k_i         (k_q),
    .next_term_o (term_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      n_last_q <= '0;
      k_q      <= '0;
      x2_q     <= '0;
      term_q   <= '0;
      acc_q    <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            x_q      <= x_d;
            n_last_q <= n_last_d;
            state_q  <= INIT;
          end
        end
        INIT: begin
          x2_q   <= x2_d;
          term_q <= ONE_IW;
          acc_q  <= ONE_IW;
          k_q    <= K_W'(1);
          if (n_last_q == '0) begin
            out_q   <= sat_q214(ONE_IW);
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= ITER;
          end
        end
        ITER: begin
          term_q <= term_d;
          acc_q  <= acc_d;
          k_q    <= k_q + 1'b1;
          if (k_q == n_last_q) begin
            out_q   <= sat_q214(acc_d);
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out  = out_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_cos_x.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_cos_x : vector table, handshake/abort sequences, random runs vs real model
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_cos_x;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] inX;
  logic [7:0]  inY;
  logic [15:0] out;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  cos_x dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .inX   (inX),
    .inY   (inY),
    .out   (out),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] x;
    logic [7:0]  n;
    logic [15:0] exp;
    int          tol;
    int          lat;
  } vec_t;

  vec_t        vecs[8];
  logic [15:0] res;
  logic [15:0] hs_res;
  logic [15:0] rx;
  logic [7:0]  rn;
  logic [5:0]  pat;
  int          lat;
  int          ndone;
  int          early;
  int          idle_bad;
  int          hs_lat;
  int          dv;

  function automatic int n_eff(input logic [7:0] n);
    if (n == 8'd0) return 1;
    if (n > 8'd16) return 16;
    return int'(n);
  endfunction

  // Real-valued truncated series, then floor to Q2.14 with saturation.
  function automatic int ref_cos(input logic [15:0] x, input logic [7:0] n);
    real xr, t, s, r;
    int  xi, ne, iv;
    xi = (x > 16'h01FF) ? 511 : int'(x);
    xr = real'(xi) / 256.0;
    ne = n_eff(n);
    t  = 1.0;
    s  = 1.0;
    for (int k = 1; k < ne; k++) begin
      t = -t * xr * xr / real'((2 * k - 1) * (2 * k));
      s = s + t;
    end
    if (s >= 2.0) return 32767;
    if (s < -2.0) return -32768;
    r  = s * 16384.0;
    iv = $rtoi(r);
    if (r < 0.0 && real'(iv) != r) iv = iv - 1;
    return iv;
  endfunction

  task automatic check(input string name, input int got, input int exp, input int tol);
    int d;
    n_tests++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) tol %0d",
               name, got, got[15:0], exp, exp[15:0], tol);
    end
  endtask

  // Inputs are scrambled right after acceptance; the result must not care.
  task automatic run_op(input logic [15:0] x, input logic [7:0] n,
                        output logic [15:0] r, output int l);
    r = '0;
    l = 0;
    @(negedge clk);
    inX   = x;
    inY   = n;
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        inX   = 16'($urandom);
        inY   = 8'($urandom);
      end
      if (done) begin
        l = c;
        r = out;
        break;
      end
    end
    @(negedge clk);
    check("done_pulse_width", int'(done), 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"nominal", 16'h0114, 8'd16,  16'h1E45, 4, 17};
    vecs[1] = '{"n_zero",  16'h0114, 8'd0,   16'h4000, 0, 2};
    vecs[2] = '{"n_one",   16'h0114, 8'd1,   16'h4000, 0, 2};
    vecs[3] = '{"n_two",   16'h0114, 8'd2,   16'h1ACE, 4, 3};
    vecs[4] = '{"n_200",   16'h0114, 8'd200, 16'h1E45, 4, 17};
    vecs[5] = '{"x_ffff",  16'hFFFF, 8'd16,  16'hE598, 4, 17};
    vecs[6] = '{"x_200",   16'h0200, 8'd17,  16'hE598, 4, 17};
    vecs[7] = '{"x_zero",  16'h0000, 8'd16,  16'h4000, 0, 17};

    rst   = 1'b0;
    start = 1'b0;
    inX   = 16'h0114;
    inY   = 8'd16;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = ~start;
      check("reset_out", int'(out), 0, 0);
      check("reset_done", int'(done), 0, 0);
    end
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].x, vecs[i].n, res, lat);
      check({vecs[i].name, "_out"}, int'($signed(res)), int'($signed(vecs[i].exp)), vecs[i].tol);
      check({vecs[i].name, "_lat"}, lat, vecs[i].lat, 0);
    end

    // start held high: single-term runs back to back, done at cycles 2 and 5
    @(negedge clk);
    inX   = 16'h0114;
    inY   = 8'd1;
    start = 1'b1;
    pat   = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      pat[c-1] = done;
    end
    start = 1'b0;
    check("held_start_pattern", int'(pat), int'(6'b010010), 0);

    // start re-pulsed mid-run; out was 0x4000 and must hold until DONE
    @(negedge clk);
    inX      = 16'h0114;
    inY      = 8'd16;
    start    = 1'b1;
    ndone    = 0;
    early    = 0;
    idle_bad = 0;
    hs_lat   = 0;
    hs_res   = '0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 5) start = 1'b1;
      if (c == 6) start = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          hs_lat = c;
          hs_res = out;
        end
      end else if (ndone == 0) begin
        if (out != 16'h4000) early++;
      end else begin
        dv = int'($signed(out)) - int'($signed(16'h1E45));
        if (dv > 4 || dv < -4) idle_bad++;
      end
    end
    check("hs_done_count", ndone, 1, 0);
    check("hs_latency", hs_lat, 17, 0);
    check("hs_out", int'($signed(hs_res)), int'($signed(16'h1E45)), 4);
    check("hs_hold_during_run", early, 0, 0);
    check("hs_hold_after_done", idle_bad, 0, 0);

    // abort at cycle 8 of a 16-term run
    @(negedge clk);
    inX   = 16'h0114;
    inY   = 8'd16;
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    rst = 1'b0;
    #1;
    check("abort_out", int'(out), 0, 0);
    check("abort_done", int'(done), 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b1;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0, 0);
    check("abort_out_held", int'(out), 0, 0);
    run_op(16'h0114, 8'd16, res, lat);
    check("abort_rerun_out", int'($signed(res)), int'($signed(16'h1E45)), 4);
    check("abort_rerun_lat", lat, 17, 0);

    for (int i = 0; i < 30; i++) begin
      rx = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 511)) : 16'($urandom);
      rn = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 18));
      run_op(rx, rn, res, lat);
      check("rand_out", int'($signed(res)), ref_cos(rx, rn), 4);
      check("rand_lat", lat, n_eff(rn) + 1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
